term_uart_rx: RTL

Synthesizable 8N1 UART receiver for the SoC terminal path. It recovers bytes from the asynchronous serial line (GPIO bit 16 in the demo SoC) and buffers them in a small FIFO. It presents them on a valid/ready byte stream to the peripheral bus wrapper. It uses 16x oversampling with mid-bit majority voting, and reports framing and overrun errors as single-cycle pulses.

---
 rtl/term_uart_pkg.sv | 28 ++
 rtl/term_uart_fifo.sv | 51 +++++
 rtl/term_uart_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/term_uart_pkg.sv
// Shared types and constants for the terminal UART receiver: FSM states,
// oversampling constants and the prescaler divisor helper.
package term_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OS_RATE = 16;

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  // Rounded clocks-per-oversample-tick.
  function automatic int div_calc(input int clk_freq_hz, input int baud);
    return (clk_freq_hz + (OS_RATE / 2) * baud) / (OS_RATE * baud);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/term_uart_fifo.sv
// Small synchronous byte FIFO; head is exposed combinationally and a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module term_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/term_uart_rx.sv
// term_uart_rx: 8N1 UART receiver, 16x oversampling with 2-of-3 mid-bit vote,
// byte FIFO on a valid/ready stream. Define TERM_UART_RX_PARITY_EN for 8E1.
module term_uart_rx
  import term_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef TERM_UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV = div_calc(CLK_FREQ_HZ, BAUD);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic          rx_meta;
  logic          rx_s;
  logic          rx_d;
  rx_state_t     state;
  logic [PW-1:0] presc;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          s_a;
  logic          s_b;
  logic          armed;
  logic          tick;
  logic          decide;
  logic          maj;
  logic          start_det;
  logic          par_ok;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign tick      = (presc == DIV_LAST);
  assign decide    = tick && (os_cnt == SAMPLE_C);
  assign maj       = maj3(s_a, s_b, rx_s);
  // armed lets a start edge that lands during the stop bit still be caught.
  assign start_det = ~rx_s & (rx_d | armed);

`ifdef TERM_UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  assign fifo_pop  = rx_valid & rx_ready;
  assign fifo_push = (state == STOP) && decide && maj && par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      armed      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef TERM_UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef TERM_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        presc  <= '0;
        os_cnt <= os_cnt + 4'd1;
      end else begin
        presc  <= presc + PW'(1);
      end
      if (tick && os_cnt == SAMPLE_A) s_a <= rx_s;
      if (tick && os_cnt == SAMPLE_B) s_b <= rx_s;

      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_det) begin
            presc  <= '0;
            os_cnt <= '0;
            armed  <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (decide) begin
            if (!maj) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg   <= {maj, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef TERM_UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef TERM_UART_RX_PARITY_EN
        PARITY: begin
          if (decide) begin
            par_bit <= maj;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (rx_s) armed <= 1'b1;
          if (decide) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (!maj) frame_err <= 1'b1;
`ifdef TERM_UART_RX_PARITY_EN
            else if (!par_ok) parity_err <= 1'b1;
`endif
            else if (fifo_full && !fifo_pop) overrun <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  term_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(shreg),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_head;

endmodule
